// File: rtl/memu_pkg.sv
// memu_pkg: shared types and helpers for the memory-access stage.
//   - BUS_64        : data bus width
//   - mem_size_e    : access size encoding (byte/half/word/double)
//   - memu_state_e  : stage FSM states
//   - size_mask()   : byte-strobe mask for an access size, LSB-justified
//   - align_bits()  : low address bits that must be zero for a naturally aligned access
package memu_pkg;

    localparam int unsigned BUS_64 = 64;

    typedef enum logic [1:0] {
        MemSizeB = 2'd0,
        MemSizeH = 2'd1,
        MemSizeW = 2'd2,
        MemSizeD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } memu_state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (mem_size_e'(size))
            MemSizeB: m = 8'h01;
            MemSizeH: m = 8'h03;
            MemSizeW: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] align_bits(input logic [1:0] size);
        logic [2:0] a;
        unique case (mem_size_e'(size))
            MemSizeB: a = 3'b000;
            MemSizeH: a = 3'b001;
            MemSizeW: a = 3'b011;
            default:  a = 3'b111;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/memu_lsext.sv
// memu_lsext: combinational load aligner / extender.
// Shifts the 64-bit bus word down by the byte offset, truncates to the access
// size and sign- or zero-extends back to 64 bits.
//   rdata       in  64  raw bus read data
//   off         in  3   byte offset within the doubleword
//   size        in  2   access size (mem_size_e)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   ext_data    out 64  aligned, extended load result
module memu_lsext
    import memu_pkg::*;
(
    input  logic [BUS_64-1:0] rdata,
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [BUS_64-1:0] ext_data
);

    logic [BUS_64-1:0] raw;

    always_comb begin
        raw      = rdata >> {off, 3'b000};
        ext_data = raw;
        unique case (mem_size_e'(size))
            MemSizeB: ext_data = is_unsigned ? {56'b0, raw[7:0]}
                                             : {{56{raw[7]}}, raw[7:0]};
            MemSizeH: ext_data = is_unsigned ? {48'b0, raw[15:0]}
                                             : {{48{raw[15]}}, raw[15:0]};
            MemSizeW: ext_data = is_unsigned ? {32'b0, raw[31:0]}
                                             : {{32{raw[31]}}, raw[31:0]};
            default:  ext_data = raw;
        endcase
    end

endmodule

// File: rtl/memu.sv
// memu: memory-access stage between EX and wbU.
// Accepts one instruction from EX (valid/ready), passes non-memory results
// through after one register stage, and runs a single 64-bit data-bus
// transaction for loads/stores. Results go to wbU with a one-cycle
// wb_valid_o strobe; rd_o/rd_wen_o/rd_wdata_o hold between strobes.
// Optional macro MEMU_MISALIGN_EXC_EN: misaligned accesses skip the bus and
// report misalign_o with the strobe; when undefined, the low address bits are
// forced to size alignment instead.
// Ports:
//   clk, rst                 clock, async active-high reset
//   ex_*                     instruction from EX; ex_ready_o high only in IDLE
//   mem_*                    load/store controls, address, store data
//   dbus_*                   data bus request/response
//   wb_valid_o, rd_*         result to wbU
//   misalign_o               misalignment flag (macro builds only)
module memu
    import memu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_rd_wen_i,
    input  logic [BUS_64-1:0] ex_rd_wdata_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic [BUS_64-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [BUS_64-1:0] mem_wdata_i,
    output logic              dbus_req_o,
    input  logic              dbus_ready_i,
    output logic              dbus_we_o,
    output logic [BUS_64-1:0] dbus_addr_o,
    output logic [BUS_64-1:0] dbus_wdata_o,
    output logic [7:0]        dbus_wstrb_o,
    input  logic              dbus_rvalid_i,
    input  logic [BUS_64-1:0] dbus_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        rd_o,
    output logic              rd_wen_o,
`ifdef MEMU_MISALIGN_EXC_EN
    output logic              misalign_o,
`endif
    output logic [BUS_64-1:0] rd_wdata_o
);

    memu_state_e state_q, state_d;

    // Latched transaction
    logic              is_load_q;
    logic              we_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [4:0]        pend_rd_q;
    logic              pend_wen_q;
    logic [BUS_64-1:0] dbus_addr_q;
    logic [BUS_64-1:0] dbus_wdata_q;
    logic [7:0]        dbus_wstrb_q;

    // Result register
    logic [4:0]        rd_q;
    logic              rd_wen_q;
    logic [BUS_64-1:0] rd_wdata_q;

    logic              accept;
    logic              is_mem_in;
    logic              is_load_in;
    logic              wen_in;
    logic              misalign_in;
    logic [2:0]        off_in;
    logic [BUS_64-1:0] load_data;

    assign accept     = ex_valid_i && (state_q == StIdle);
    assign is_mem_in  = mem_ren_i || mem_wen_i;
    assign is_load_in = mem_ren_i;  // load wins when both are set
    // Stores never write rd; x0 is never written.
    assign wen_in     = ex_rd_wen_i && (ex_rd_i != 5'd0) && !(is_mem_in && !is_load_in);

`ifdef MEMU_MISALIGN_EXC_EN
    logic misalign_q;
    assign misalign_in = is_mem_in && ((mem_addr_i[2:0] & align_bits(mem_size_i)) != 3'b000);
    assign off_in      = mem_addr_i[2:0];
    assign misalign_o  = misalign_q && (state_q == StDone);
`else
    assign misalign_in = 1'b0;
    assign off_in      = mem_addr_i[2:0] & ~align_bits(mem_size_i);
`endif

    memu_lsext u_lsext (
        .rdata       (dbus_rdata_i),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext_data    (load_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (!is_mem_in || misalign_in) ? StDone : StReq;
                end
            end
            StReq:  if (dbus_ready_i) state_d = StWait;
            StWait: if (dbus_rvalid_i) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q    <= 1'b0;
            we_q         <= 1'b0;
            off_q        <= 3'b0;
            size_q       <= 2'b0;
            uns_q        <= 1'b0;
            pend_rd_q    <= 5'b0;
            pend_wen_q   <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            dbus_wstrb_q <= 8'b0;
            rd_q         <= 5'b0;
            rd_wen_q     <= 1'b0;
            rd_wdata_q   <= '0;
`ifdef MEMU_MISALIGN_EXC_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
`ifdef MEMU_MISALIGN_EXC_EN
                misalign_q <= misalign_in;
`endif
                if (!is_mem_in || misalign_in) begin
                    // Result is known now; publish it for the DONE strobe.
                    rd_q     <= ex_rd_i;
                    rd_wen_q <= wen_in && !misalign_in;
                    if (!is_mem_in) begin
                        rd_wdata_q <= ex_rd_wdata_i;
                    end
                end else begin
                    is_load_q    <= is_load_in;
                    we_q         <= !is_load_in;
                    off_q        <= off_in;
                    size_q       <= mem_size_i;
                    uns_q        <= mem_unsigned_i;
                    pend_rd_q    <= ex_rd_i;
                    pend_wen_q   <= wen_in;
                    dbus_addr_q  <= {mem_addr_i[BUS_64-1:3], 3'b000};
                    dbus_wdata_q <= is_load_in ? '0 : (mem_wdata_i << {off_in, 3'b000});
                    dbus_wstrb_q <= is_load_in ? 8'b0 : (size_mask(mem_size_i) << off_in);
                end
            end
            if ((state_q == StWait) && dbus_rvalid_i) begin
                rd_q     <= pend_rd_q;
                rd_wen_q <= pend_wen_q;
                if (is_load_q) begin
                    rd_wdata_q <= load_data;
                end
            end
        end
    end

    assign ex_ready_o   = (state_q == StIdle);
    assign dbus_req_o   = (state_q == StReq);
    assign dbus_we_o    = we_q && (state_q == StReq);
    assign dbus_addr_o  = dbus_addr_q;
    assign dbus_wdata_o = dbus_wdata_q;
    assign dbus_wstrb_o = dbus_wstrb_q;
    assign wb_valid_o   = (state_q == StDone);
    assign rd_o         = rd_q;
    assign rd_wen_o     = rd_wen_q;
    assign rd_wdata_o   = rd_wdata_q;

endmodule

// File: tb/tb_memu.sv
// tb_memu: directed bench for memu with a result scoreboard.
// Expected wbU results are queued as each instruction is driven and compared
// by a monitor whenever wb_valid_o is seen.
module tb_memu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic        ex_rd_wen_i;
    logic [63:0] ex_rd_wdata_i;
    logic        mem_ren_i, mem_wen_i;
    logic [63:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [63:0] mem_wdata_i;
    logic        dbus_req_o, dbus_ready_i, dbus_we_o;
    logic [63:0] dbus_addr_o, dbus_wdata_o;
    logic [7:0]  dbus_wstrb_o;
    logic        dbus_rvalid_i;
    logic [63:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  rd_o;
    logic        rd_wen_o;
    logic [63:0] rd_wdata_o;
`ifdef MEMU_MISALIGN_EXC_EN
    logic        misalign_o;
`endif

    memu dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .ex_ready_o     (ex_ready_o),
        .ex_rd_i        (ex_rd_i),
        .ex_rd_wen_i    (ex_rd_wen_i),
        .ex_rd_wdata_i  (ex_rd_wdata_i),
        .mem_ren_i      (mem_ren_i),
        .mem_wen_i      (mem_wen_i),
        .mem_addr_i     (mem_addr_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .mem_wdata_i    (mem_wdata_i),
        .dbus_req_o     (dbus_req_o),
        .dbus_ready_i   (dbus_ready_i),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_wstrb_o   (dbus_wstrb_o),
        .dbus_rvalid_i  (dbus_rvalid_i),
        .dbus_rdata_i   (dbus_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .rd_o           (rd_o),
        .rd_wen_o       (rd_wen_o),
`ifdef MEMU_MISALIGN_EXC_EN
        .misalign_o     (misalign_o),
`endif
        .rd_wdata_o     (rd_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        chk_wdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_wb     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Result monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            n_wb++;
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rd_o", 64'(rd_o), 64'(e.rd));
                check("rd_wen_o", 64'(rd_wen_o), 64'(e.wen));
                if (e.chk_wdata) check("rd_wdata_o", rd_wdata_o, e.wdata);
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic wen, input logic [63:0] wdata,
                        input logic chk);
        exp_t e;
        e.rd = rd; e.wen = wen; e.wdata = wdata; e.chk_wdata = chk;
        sb.push_back(e);
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [63:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                         input logic [4:0] rd, input logic rd_wen);
        ex_valid_i = 1'b1; ex_rd_i = rd; ex_rd_wen_i = rd_wen; ex_rd_wdata_i = 64'hBAD0;
        mem_ren_i = ren; mem_wen_i = wen; mem_addr_i = addr; mem_size_i = size;
        mem_unsigned_i = uns; mem_wdata_i = wdata;
    endtask

    task automatic idle_inputs;
        ex_valid_i = 1'b0; mem_ren_i = 1'b0; mem_wen_i = 1'b0;
    endtask

    // Full bus transaction, with ready/rvalid stalls; starts in an IDLE cycle.
    task automatic mem_txn(input string tag, input logic ren, input logic wen,
                           input logic [63:0] addr, input logic [1:0] size, input logic uns,
                           input logic [63:0] wdata, input logic [4:0] rd,
                           input logic rd_wen, input int rdy_dly, input int rv_dly,
                           input logic [63:0] rdata, input logic [63:0] exp_addr,
                           input logic exp_we, input logic [63:0] exp_bwdata,
                           input logic [7:0] exp_strb);
        drive(ren, wen, addr, size, uns, wdata, rd, rd_wen);
        tick;
        idle_inputs();
        for (int i = 0; i <= rdy_dly; i++) begin
            check({tag, "_req"}, 64'(dbus_req_o), 64'd1);
            check({tag, "_addr"}, dbus_addr_o, exp_addr);
            check({tag, "_rdy_lo"}, 64'(ex_ready_o), 64'd0);
            if (i == 0) begin
                check({tag, "_we"}, 64'(dbus_we_o), 64'(exp_we));
                if (exp_we) begin
                    check({tag, "_bwdata"}, dbus_wdata_o, exp_bwdata);
                    check({tag, "_wstrb"}, 64'(dbus_wstrb_o), 64'(exp_strb));
                end
            end
            if (i == rdy_dly) dbus_ready_i = 1'b1;
            tick;
        end
        dbus_ready_i = 1'b0;
        for (int j = 0; j <= rv_dly; j++) begin
            check({tag, "_req_dropped"}, 64'(dbus_req_o), 64'd0);
            check({tag, "_wait_nowb"}, 64'(wb_valid_o), 64'd0);
            check({tag, "_wait_rdy_lo"}, 64'(ex_ready_o), 64'd0);
            if (j == rv_dly) begin
                dbus_rvalid_i = 1'b1;
                dbus_rdata_i  = rdata;
            end
            tick;
        end
        dbus_rvalid_i = 1'b0;
        check({tag, "_wb"}, 64'(wb_valid_o), 64'd1);
        check({tag, "_done_rdy_lo"}, 64'(ex_ready_o), 64'd0);
        tick;
        check({tag, "_wb_pulse"}, 64'(wb_valid_o), 64'd0);
        check({tag, "_rdy_back"}, 64'(ex_ready_o), 64'd1);
    endtask

    initial begin
        int wb_before;
        rst = 1'b1;
        ex_valid_i = 1'b0; ex_rd_i = '0; ex_rd_wen_i = 1'b0; ex_rd_wdata_i = '0;
        mem_ren_i = 1'b0; mem_wen_i = 1'b0; mem_addr_i = '0; mem_size_i = '0;
        mem_unsigned_i = 1'b0; mem_wdata_i = '0;
        dbus_ready_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
        tick;
        tick;
        check("rst_ex_ready", 64'(ex_ready_o), 64'd1);
        check("rst_req", 64'(dbus_req_o), 64'd0);
        check("rst_we", 64'(dbus_we_o), 64'd0);
        check("rst_addr", dbus_addr_o, 64'd0);
        check("rst_wstrb", 64'(dbus_wstrb_o), 64'd0);
        check("rst_wb", 64'(wb_valid_o), 64'd0);
        check("rst_rd_wdata", rd_wdata_o, 64'd0);
        rst = 1'b0;
        tick;

        // ALU pass-through, twice back to back (one op every 2 cycles)
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 64'h0, 2'd0, 1'b0, 64'h0, 5'd5, 1'b1);
            ex_rd_wdata_i = 64'h1234 + 64'(k);
            push(5'd5, 1'b1, 64'h1234 + 64'(k), 1'b1);
            tick;
            idle_inputs();
            check("alu_wb_t1", 64'(wb_valid_o), 64'd1);
            check("alu_rdy_lo", 64'(ex_ready_o), 64'd0);
            tick;
            check("alu_wb_pulse", 64'(wb_valid_o), 64'd0);
        end

        // Signed byte load
        push(5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        mem_txn("lb", 1'b1, 1'b0, 64'h8000_0003, 2'd0, 1'b0, 64'h0, 5'd7, 1'b1, 0, 0,
                64'h0000_0000_8000_0000, 64'h8000_0000, 1'b0, 64'h0, 8'h0);

        // Unsigned half load at offset 6
        push(5'd8, 1'b1, 64'h0000_0000_0000_BEEF, 1'b1);
        mem_txn("lhu", 1'b1, 1'b0, 64'h1006, 2'd1, 1'b1, 64'h0, 5'd8, 1'b1, 0, 0,
                64'hBEEF_0000_0000_0000, 64'h1000, 1'b0, 64'h0, 8'h0);

        // Word store at offset 4
        push(5'd9, 1'b0, 64'h0, 1'b0);
        mem_txn("sw", 1'b0, 1'b1, 64'h2004, 2'd2, 1'b0, 64'hDEAD_BEEF, 5'd9, 1'b1, 0, 0,
                64'h0, 64'h2000, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0);

        // Byte store at offset 7
        push(5'd3, 1'b0, 64'h0, 1'b0);
        mem_txn("sb", 1'b0, 1'b1, 64'h2007, 2'd0, 1'b0, 64'h5A, 5'd3, 1'b1, 0, 0,
                64'h0, 64'h2000, 1'b1, 64'h5A00_0000_0000_0000, 8'h80);

        // Backpressure: ready late by 3, rvalid late by 2, single strobe
        wb_before = n_wb;
        push(5'd10, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        mem_txn("bp", 1'b1, 1'b0, 64'h3000, 2'd3, 1'b0, 64'h0, 5'd10, 1'b1, 3, 2,
                64'h0123_4567_89AB_CDEF, 64'h3000, 1'b0, 64'h0, 8'h0);
        check("bp_one_wb", 64'(n_wb - wb_before), 64'd1);

        // Signed half load to x0: write enable suppressed
        push(5'd0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
        mem_txn("lh_x0", 1'b1, 1'b0, 64'h4002, 2'd1, 1'b0, 64'h0, 5'd0, 1'b1, 0, 0,
                64'h0000_0000_8001_0000, 64'h4000, 1'b0, 64'h0, 8'h0);

        // ren and wen both set: treated as a load
        push(5'd11, 1'b1, 64'h55, 1'b1);
        mem_txn("both", 1'b1, 1'b1, 64'h4008, 2'd3, 1'b1, 64'hFF, 5'd11, 1'b1, 0, 1,
                64'h55, 64'h4008, 1'b0, 64'h0, 8'h0);

`ifdef MEMU_MISALIGN_EXC_EN
        // Misaligned word load: no bus request, immediate strobe with flag
        drive(1'b1, 1'b0, 64'h5002, 2'd2, 1'b0, 64'h0, 5'd12, 1'b1);
        push(5'd12, 1'b0, 64'h0, 1'b0);
        tick;
        idle_inputs();
        check("mis_noreq", 64'(dbus_req_o), 64'd0);
        check("mis_wb", 64'(wb_valid_o), 64'd1);
        check("mis_flag", 64'(misalign_o), 64'd1);
        tick;
        check("mis_flag_clr", 64'(misalign_o), 64'd0);
`else
        // Misaligned word load: offset forced down to 0
        push(5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        mem_txn("lw_fix", 1'b1, 1'b0, 64'h5002, 2'd2, 1'b0, 64'h0, 5'd12, 1'b1, 0, 0,
                64'h1111_1111_FFFF_FFFE, 64'h5000, 1'b0, 64'h0, 8'h0);
`endif

        // Reset during WAIT abandons the transaction
        drive(1'b1, 1'b0, 64'h6000, 2'd3, 1'b0, 64'h0, 5'd13, 1'b1);
        tick;
        idle_inputs();
        check("rw_req", 64'(dbus_req_o), 64'd1);
        dbus_ready_i = 1'b1;
        tick;
        dbus_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rw_rst_rdy", 64'(ex_ready_o), 64'd1);
        check("rw_rst_req", 64'(dbus_req_o), 64'd0);
        check("rw_rst_addr", dbus_addr_o, 64'd0);
        check("rw_rst_rd", 64'(rd_o), 64'd0);
        check("rw_rst_wdata", rd_wdata_o, 64'd0);
        tick;
        rst = 1'b0;
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = 64'hAAAA;
        tick;
        dbus_rvalid_i = 1'b0;
        check("rw_late_nowb", 64'(wb_valid_o), 64'd0);
        tick;
        check("rw_late_nowb2", 64'(wb_valid_o), 64'd0);
        check("rw_idle", 64'(ex_ready_o), 64'd1);

        tick;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
